// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive/transmit pair: FSM state encoding
// and the clocks-per-bit calculation both directions must agree on.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } uart_state_t;

  function automatic int unsigned calc_bit_period(input int unsigned clock_freq,
                                                  input int unsigned baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous RX pin plus a delayed copy used
// to detect the start-bit falling edge. All flops reset to the idle-high level.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic s2,
  output logic fall
);

  logic s1;
  logic s2_d;

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour; blocking here would collapse
  // the synchronizer chain into a single stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      s2_d <= 1'b1;
    end else begin
      s1   <= rx;
      s2   <= s1;
      s2_d <= s2;
    end
  end

  assign fall = s2_d & ~s2;

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: mid-bit sampling of a synchronized line, LSB first,
// one-cycle rx_done strobe per good frame and a sticky framing-error flag.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_RATE  = 9600,
  parameter int CLOCK_FREQ = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_busy,
  output logic       frame_err,
  output logic [7:0] LED
);

  localparam int BIT_PERIOD  = int'(calc_bit_period(CLOCK_FREQ, BAUD_RATE));
  localparam int HALF_PERIOD = BIT_PERIOD / 2;
  localparam logic [15:0] BIT_LAST  = 16'(BIT_PERIOD - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF_PERIOD - 1);

  uart_state_t state;
  logic [15:0] clk_count;
  logic [2:0]  bit_index;
  logic [7:0]  shift;
  logic        s2;
  logic        fall;

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .s2    (s2),
    .fall  (fall)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      clk_count <= '0;
      bit_index <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_done   <= 1'b0;
      rx_busy   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      case (state)
        IDLE: begin
          clk_count <= '0;
          bit_index <= '0;
          if (fall) begin
            state   <= START;
            rx_busy <= 1'b1;
          end
        end

        START: begin
          if (clk_count == HALF_LAST) begin
            clk_count <= '0;
            if (!s2) begin
              state <= DATA;
            end else begin
              // Line went back high before mid-start: treat as a glitch.
              state   <= IDLE;
              rx_busy <= 1'b0;
            end
          end else begin
            clk_count <= clk_count + 16'd1;
          end
        end

        DATA: begin
          if (clk_count == BIT_LAST) begin
            clk_count <= '0;
            shift     <= {s2, shift[7:1]};
            bit_index <= bit_index + 3'd1;
            if (bit_index == 3'd7) state <= STOP;
          end else begin
            clk_count <= clk_count + 16'd1;
          end
        end

        STOP: begin
          if (clk_count == BIT_LAST) begin
            // Leaving at mid-stop-bit keeps half a bit of slack for a
            // back-to-back start edge.
            clk_count <= '0;
            state     <= IDLE;
            rx_busy   <= 1'b0;
            if (s2) begin
              rx_data   <= shift;
              rx_done   <= 1'b1;
              frame_err <= 1'b0;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            clk_count <= clk_count + 16'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign LED = rx_data;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: framing, timing, glitch
// rejection, framing error, mid-frame reset and a slightly slow sender.
module tb_uart_rx;

  localparam int CLOCK_FREQ = 160;
  localparam int BAUD_RATE  = 10;
  localparam int FRAME_LEN  = 160;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_busy;
  logic       frame_err;
  logic [7:0] LED;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_cyc = 0;
  logic [7:0] data_q[$];
  int         cyc_q[$];

  always #5 clk = ~clk;

  uart_rx #(.BAUD_RATE(BAUD_RATE), .CLOCK_FREQ(CLOCK_FREQ)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
    .LED       (LED)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Record every rx_done strobe with its cycle and byte, and count busy cycles.
  always @(negedge clk) begin
    if (rx_done) begin
      data_q.push_back(rx_data);
      cyc_q.push_back(cyc);
    end
    if (rx_busy) busy_cyc <= busy_cyc + 1;
  end

  // Drive one frame starting at a negedge; frame_len clocks split over 10 bits.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int frame_len);
    for (int k = 0; k < 10; k++) begin
      int dur;
      dur = ((k + 1) * frame_len) / 10 - (k * frame_len) / 10;
      if (k == 0)      rx = 1'b0;
      else if (k == 9) rx = stop;
      else             rx = d[k-1];
      repeat (dur) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (rx_data !== 8'h00)  begin errors++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
    checks++; if (rx_done !== 1'b0)   begin errors++; $display("FAIL reset_rx_done got %b want 0", rx_done); end
    checks++; if (rx_busy !== 1'b0)   begin errors++; $display("FAIL reset_rx_busy got %b want 0", rx_busy); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    checks++; if (LED !== 8'h00)      begin errors++; $display("FAIL reset_led got %h want 00", LED); end
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single_byte;
    int base, c0, dt;
    base = data_q.size();
    c0 = cyc;
    send_frame(8'hA5, 1'b1, FRAME_LEN);
    repeat (10) @(negedge clk);
    checks++; if (data_q.size() - base !== 1) begin errors++; $display("FAIL a5_pulses got %0d want 1", data_q.size() - base); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL a5_rx_data got %h want a5", rx_data); end
    checks++; if (LED !== 8'hA5) begin errors++; $display("FAIL a5_led got %h want a5", LED); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL a5_frame_err got %b want 0", frame_err); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL a5_busy_after got %b want 0", rx_busy); end
    if (data_q.size() > base) begin
      dt = cyc_q[base] - c0;
      checks++; if (dt < 154 || dt > 156) begin errors++; $display("FAIL a5_latency got %0d want 155+-1", dt); end
    end
  endtask

  task automatic test_back_to_back;
    int base;
    base = data_q.size();
    send_frame(8'h00, 1'b1, FRAME_LEN);
    send_frame(8'hFF, 1'b1, FRAME_LEN);
    repeat (10) @(negedge clk);
    checks++;
    if (data_q.size() - base !== 2) begin
      errors++; $display("FAIL b2b_pulses got %0d want 2", data_q.size() - base);
    end else begin
      checks++; if (data_q[base] !== 8'h00)   begin errors++; $display("FAIL b2b_first got %h want 00", data_q[base]); end
      checks++; if (data_q[base+1] !== 8'hFF) begin errors++; $display("FAIL b2b_second got %h want ff", data_q[base+1]); end
      checks++; if (cyc_q[base+1] - cyc_q[base] !== 160) begin
        errors++; $display("FAIL b2b_spacing got %0d want 160", cyc_q[base+1] - cyc_q[base]);
      end
    end
  endtask

  task automatic test_glitch;
    int base, b0;
    base = data_q.size();
    b0 = busy_cyc;
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    checks++; if (data_q.size() - base !== 0) begin errors++; $display("FAIL glitch_pulses got %0d want 0", data_q.size() - base); end
    checks++; if (busy_cyc - b0 !== 8) begin errors++; $display("FAIL glitch_busy_cycles got %0d want 8", busy_cyc - b0); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_after got %b want 0", rx_busy); end
    checks++; if (rx_data !== 8'hFF) begin errors++; $display("FAIL glitch_rx_data got %h want ff", rx_data); end
  endtask

  task automatic test_frame_error;
    int base;
    base = data_q.size();
    send_frame(8'h3C, 1'b0, FRAME_LEN);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_set got %b want 1", frame_err); end
    checks++; if (data_q.size() - base !== 0) begin errors++; $display("FAIL ferr_pulses got %0d want 0", data_q.size() - base); end
    checks++; if (rx_data !== 8'hFF) begin errors++; $display("FAIL ferr_rx_data got %h want ff", rx_data); end
    send_frame(8'h11, 1'b1, FRAME_LEN);
    repeat (10) @(negedge clk);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_clear got %b want 0", frame_err); end
    checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL ferr_next_data got %h want 11", rx_data); end
    checks++; if (data_q.size() - base !== 1) begin errors++; $display("FAIL ferr_next_pulses got %0d want 1", data_q.size() - base); end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] d;
    int base;
    d = 8'h55;
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      repeat (16) @(negedge clk);
    end
    rx = d[4];
    repeat (8) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (rx_data !== 8'h00)  begin errors++; $display("FAIL midrst_rx_data got %h want 00", rx_data); end
    checks++; if (rx_busy !== 1'b0)   begin errors++; $display("FAIL midrst_busy got %b want 0", rx_busy); end
    checks++; if (rx_done !== 1'b0)   begin errors++; $display("FAIL midrst_done got %b want 0", rx_done); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL midrst_frame_err got %b want 0", frame_err); end
    checks++; if (LED !== 8'h00)      begin errors++; $display("FAIL midrst_led got %h want 00", LED); end
    rx = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    base = data_q.size();
    repeat (20) @(negedge clk);
    checks++; if (data_q.size() - base !== 0) begin errors++; $display("FAIL midrst_pulses got %0d want 0", data_q.size() - base); end
    send_frame(8'h55, 1'b1, FRAME_LEN);
    repeat (10) @(negedge clk);
    checks++; if (rx_data !== 8'h55) begin errors++; $display("FAIL midrst_next_data got %h want 55", rx_data); end
    checks++; if (data_q.size() - base !== 1) begin errors++; $display("FAIL midrst_next_pulses got %0d want 1", data_q.size() - base); end
  endtask

  task automatic test_slow_sender;
    int base;
    base = data_q.size();
    for (int f = 0; f < 8; f++) send_frame(8'h96, 1'b1, 161);
    repeat (10) @(negedge clk);
    checks++;
    if (data_q.size() - base !== 8) begin
      errors++; $display("FAIL slow_pulses got %0d want 8", data_q.size() - base);
    end else begin
      for (int f = 0; f < 8; f++) begin
        checks++;
        if (data_q[base+f] !== 8'h96) begin
          errors++; $display("FAIL slow_data_%0d got %h want 96", f, data_q[base+f]);
        end
      end
    end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL slow_frame_err got %b want 0", frame_err); end
  endtask

  initial begin
    test_reset;
    test_single_byte;
    test_back_to_back;
    test_glitch;
    test_frame_error;
    test_reset_mid_frame;
    test_slow_sender;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
